light_safety_monitor: RTL and testbench
=======================================

# light_safety_monitor

Downstream stage of `Traffic_Light_Controller` that sits between its four 3-bit lamp buses and the lamp drivers. It registers the four buses through to the drivers and checks each bus for a valid encoding, a legal R→G→Y→R sequence and a minimum yellow time. It also checks for conflicting right-of-way between buses. On any violation it latches a fault code and overrides all four outputs with flashing red until the fault is cleared.

## Interface
- `MIN_YELLOW`, default 2: minimum consecutive cycles a bus must show yellow before going red (≥1).
- `GLITCH_CYC`, default 2: consecutive invalid samples on any bus that make a fault (≥1).
- `FLASH_HALF`, default 1: cycles per half-period of the fault flash (≥1).
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `light_M1` in 3: controller output, main road direction 1, {R,Y,G} = bits [2:0].
- `light_M2` in 3: main road direction 2.
- `light_MT` in 3: main road turn.
- `light_S` in 3: side road.
- `clr_fault` in 1: request to leave FAULT.
- `sig_M1`, `sig_M2`, `sig_MT`, `sig_S` out 3 each: lamp driver outputs, same encoding.
- `fault` out 1: high while in FAULT.
- `fault_code` out 3: first fault cause, sticky until cleared.

## Operation
- **Valid codes:** 100 = R, 010 = Y, 001 = G. Any other value is invalid.
- **Invalid samples:** per bus, the last valid value is held in `prev_X`. An invalid sample does not update `prev_X` and does not update `sig_X`, which holds its last valid value.
- **Invalid counter:**
  - Shared counter `inv_cnt` increments on each edge where any bus is invalid.
  - It clears on an all-valid sample and saturates at `GLITCH_CYC`.
  - A fault is raised when the sample makes `inv_cnt` reach `GLITCH_CYC`.
- **Conflict:** "Active" means Y or G, evaluated on the effective value (current sample if valid, else `prev_X`). Two pairings conflict:
  - S active together with any of M1, M2 or MT active.
  - MT active together with M2 active.
  - M1 with M2, and M1 with MT, are legal.
- **Sequence:** on each bus the allowed changes are R→G, G→Y and Y→R. R→Y, Y→G and G→R are sequence faults. An unchanged value is always legal.
- **Yellow timer:**
  - Per-bus `ycnt` counts consecutive valid Y samples, saturating at `MIN_YELLOW`.
  - On a Y→R change with `ycnt < MIN_YELLOW`, a short-yellow fault is raised.
  - `ycnt` clears on any non-Y valid sample.
- **Fault codes:** 001 invalid encoding, 010 conflict, 011 short yellow, 100 illegal sequence.
  - When several faults occur on the same edge, priority is conflict > invalid > sequence > short yellow.
- **State NORMAL:** `sig_X` <= effective value, `fault`=0. A detected fault moves to FAULT on the same edge and loads `fault_code`.
- **State FAULT:**
  - All detection is frozen.
  - All four `sig_X` flash: 100 for `FLASH_HALF` cycles, then 000 for `FLASH_HALF` cycles, repeating. The first FAULT cycle shows 100.
  - FAULT → NORMAL happens only when `clr_fault`=1 and all four inputs sample 100 on the same edge.
  - On that exit: `fault` and `fault_code` clear to 0, `prev_X` is set to 100, all `ycnt` and `inv_cnt` and the flash counter clear, and `sig_X` = 100.
  - `clr_fault` in NORMAL has no effect.

## Timing
- **Reset values:** all `sig_X`=100, `fault`=0, `fault_code`=000, state NORMAL, `prev_X`=100, all counters 0.
- **Passthrough latency:** input sampled at edge N appears on `sig_X` after edge N (1 cycle).
- **Detection latency:** a violating sample at edge N gives `fault`=1, `fault_code` valid and `sig_X`=100 (flash start) after edge N. The violating value never reaches `sig_X`.
- **Invalid-encoding latency:** with `GLITCH_CYC`=k, fault after the k-th consecutive invalid edge. Invalid runs shorter than k are absorbed with outputs held.
- **Reset mid-operation:** reset in FAULT or NORMAL returns all reset values on the next edge; reset overrides `clr_fault`.
- **Clear attempts:** a clear attempt with any input non-red is ignored; flashing continues uninterrupted.

## Test plan
- **Normal cycle:** reset, then M1/M2 drive R→G (5 cycles) →Y (2) →R, S stays R. Expect `sig_X` to follow the inputs delayed by 1 cycle, `fault`=0 throughout.
- **Conflict:** M1=G, S=G on the same edge. Expect `fault`=1 and `fault_code`=010 after that edge. `sig_*` show 100,000,100,… with `FLASH_HALF`=1.
- **Short yellow:** M2 goes G→Y for 1 cycle →R with `MIN_YELLOW`=2. Expect `fault_code`=011. A repeat with Y held 2 cycles gives no fault.
- **Invalid encoding:**
  - `light_S`=110 for 1 cycle: no fault, `sig_S` holds 100.
  - `light_S`=110 for 2 cycles: `fault_code`=001.
- **Sequence and priority:** MT goes G→R directly: `fault_code`=100. Separately, an S=G conflict and an M1 sequence fault on the same edge give `fault_code`=010.
- **Clear:**
  - In FAULT, `clr_fault`=1 with `light_M1`=001: stays in FAULT.
  - Then all inputs 100 with `clr_fault`=1: `fault`=0, `fault_code`=000, `sig_X`=100 next cycle.
  - `rst` asserted mid-flash gives reset values after 1 edge.

Source files
------------

// File: rtl/light_safety_monitor.sv
// Lamp-driver safety stage: registers four controller lamp buses to the drivers,
// checks encoding, sequencing, yellow time and right-of-way, and forces flashing red on fault.
module light_safety_monitor #(
  parameter int MIN_YELLOW = 2,
  parameter int GLITCH_CYC = 2,
  parameter int FLASH_HALF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       clr_fault,
  output logic [2:0] sig_M1,
  output logic [2:0] sig_M2,
  output logic [2:0] sig_MT,
  output logic [2:0] sig_S,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int IW = $clog2(GLITCH_CYC + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);

  localparam logic [YW-1:0] Y_MAX    = YW'(MIN_YELLOW);
  localparam logic [IW-1:0] INV_MAX  = IW'(GLITCH_CYC);
  localparam logic [IW-1:0] INV_LAST = IW'(GLITCH_CYC - 1);
  localparam logic [FW-1:0] F_LAST   = FW'(FLASH_HALF - 1);

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  localparam logic [2:0] FC_NONE  = 3'b000;
  localparam logic [2:0] FC_INV   = 3'b001;
  localparam logic [2:0] FC_CONF  = 3'b010;
  localparam logic [2:0] FC_SHORT = 3'b011;
  localparam logic [2:0] FC_SEQ   = 3'b100;

  typedef enum logic {ST_NORMAL, ST_FAULT} state_t;

  function automatic logic is_valid(input logic [2:0] v);
    return (v == L_R) || (v == L_Y) || (v == L_G);
  endfunction

  function automatic logic bad_step(input logic [2:0] prev, input logic [2:0] cur);
    return ((prev == L_R) && (cur == L_Y)) ||
           ((prev == L_Y) && (cur == L_G)) ||
           ((prev == L_G) && (cur == L_R));
  endfunction

  state_t                state_q;
  logic [3:0][2:0]       prev_q;
  logic [3:0][2:0]       sig_q;
  logic [3:0][YW-1:0]    ycnt_q;
  logic [IW-1:0]         inv_cnt_q;
  logic [FW-1:0]         fcnt_q;
  logic                  flash_off_q;

  logic [3:0][2:0]       in_bus;
  logic [3:0][2:0]       eff;
  logic [3:0][YW-1:0]    ycnt_nxt;
  logic [3:0]            vld;
  logic [3:0]            act;
  logic [3:0]            seq_err;
  logic [3:0]            short_err;
  logic [IW-1:0]         inv_nxt;
  logic                  any_inv;
  logic                  inv_hit;
  logic                  conflict;
  logic                  all_red;
  logic [2:0]            det_code;

  // Index order: 0 = M1, 1 = M2, 2 = MT, 3 = S
  always_comb begin
    in_bus = {light_S, light_MT, light_M2, light_M1};
    for (int i = 0; i < 4; i++) begin
      vld[i]       = is_valid(in_bus[i]);
      eff[i]       = vld[i] ? in_bus[i] : prev_q[i];
      act[i]       = (eff[i] == L_Y) || (eff[i] == L_G);
      seq_err[i]   = vld[i] && bad_step(prev_q[i], in_bus[i]);
      short_err[i] = vld[i] && (prev_q[i] == L_Y) && (in_bus[i] == L_R) &&
                     (ycnt_q[i] < Y_MAX);
      if (!vld[i])
        ycnt_nxt[i] = ycnt_q[i];
      else if (in_bus[i] != L_Y)
        ycnt_nxt[i] = '0;
      else if (ycnt_q[i] == Y_MAX)
        ycnt_nxt[i] = Y_MAX;
      else
        ycnt_nxt[i] = ycnt_q[i] + 1'b1;
    end
    any_inv  = ~&vld;
    all_red  = (in_bus == {4{L_R}});
    inv_hit  = any_inv && (inv_cnt_q == INV_LAST);
    if (!any_inv)
      inv_nxt = '0;
    else if (inv_cnt_q == INV_MAX)
      inv_nxt = INV_MAX;
    else
      inv_nxt = inv_cnt_q + 1'b1;
    // Side road against any main movement; turn against opposing main direction
    conflict = (act[3] && (|act[2:0])) || (act[2] && act[1]);
    if (conflict)
      det_code = FC_CONF;
    else if (inv_hit)
      det_code = FC_INV;
    else if (|seq_err)
      det_code = FC_SEQ;
    else if (|short_err)
      det_code = FC_SHORT;
    else
      det_code = FC_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_NORMAL;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      prev_q      <= {4{L_R}};
      sig_q       <= {4{L_R}};
      ycnt_q      <= '0;
      inv_cnt_q   <= '0;
      fcnt_q      <= '0;
      flash_off_q <= 1'b0;
    end else if (state_q == ST_NORMAL) begin
      if (det_code != FC_NONE) begin
        state_q     <= ST_FAULT;
        fault       <= 1'b1;
        fault_code  <= det_code;
        sig_q       <= {4{L_R}};
        fcnt_q      <= '0;
        flash_off_q <= 1'b0;
      end else begin
        sig_q     <= eff;
        prev_q    <= eff;
        ycnt_q    <= ycnt_nxt;
        inv_cnt_q <= inv_nxt;
      end
    end else begin
      // Detection state is frozen here; only the flash timer runs
      if (clr_fault && all_red) begin
        state_q     <= ST_NORMAL;
        fault       <= 1'b0;
        fault_code  <= FC_NONE;
        prev_q      <= {4{L_R}};
        sig_q       <= {4{L_R}};
        ycnt_q      <= '0;
        inv_cnt_q   <= '0;
        fcnt_q      <= '0;
        flash_off_q <= 1'b0;
      end else if (fcnt_q == F_LAST) begin
        fcnt_q      <= '0;
        flash_off_q <= ~flash_off_q;
        sig_q       <= flash_off_q ? {4{L_R}} : '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  assign sig_M1 = sig_q[0];
  assign sig_M2 = sig_q[1];
  assign sig_MT = sig_q[2];
  assign sig_S  = sig_q[3];

endmodule

// File: tb/tb_light_safety_monitor.sv
// Scoreboard bench for light_safety_monitor: a behavioural model predicts each
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_light_safety_monitor;

  localparam int MIN_Y = 2;
  localparam int GLITCH = 2;
  localparam int FHALF = 1;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] BAD = 3'b110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clr;
  logic [2:0] l_m1, l_m2, l_mt, l_s;
  logic [2:0] sig_M1, sig_M2, sig_MT, sig_S, fault_code;
  logic       fault;

  light_safety_monitor #(
    .MIN_YELLOW(MIN_Y),
    .GLITCH_CYC(GLITCH),
    .FLASH_HALF(FHALF)
  ) dut (
    .clk(clk), .rst(rst),
    .light_M1(l_m1), .light_M2(l_m2), .light_MT(l_mt), .light_S(l_s),
    .clr_fault(clr),
    .sig_M1(sig_M1), .sig_M2(sig_M2), .sig_MT(sig_MT), .sig_S(sig_S),
    .fault(fault), .fault_code(fault_code)
  );

  typedef struct packed {
    logic [11:0] sig;
    logic        flt;
    logic [2:0]  code;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference model state
  bit         m_flt;
  logic [2:0] m_code;
  logic [2:0] m_prev[4];
  logic [2:0] m_sig[4];
  int         m_ycnt[4];
  int         m_inv, m_fcnt;
  bit         m_off;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
    end
  endtask

  function automatic bit legal(input logic [2:0] p, input logic [2:0] c);
    return (p == c) || (p == R && c == G) || (p == G && c == Y) || (p == Y && c == R);
  endfunction

  task automatic model_clear();
    m_flt = 0; m_code = 3'b000; m_inv = 0; m_fcnt = 0; m_off = 0;
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = R; m_sig[i] = R; m_ycnt[i] = 0;
    end
  endtask

  task automatic model_step(input logic [2:0] m1, m2, mt, s, input logic c, input logic r);
    logic [2:0] a[4];
    logic [2:0] e[4];
    bit v[4];
    bit ac[4];
    bit anyinv, conf, seq, shrt, invf;
    int code;
    a[0] = m1; a[1] = m2; a[2] = mt; a[3] = s;
    if (r) begin
      model_clear();
    end else if (m_flt) begin
      if (c && a[0] == R && a[1] == R && a[2] == R && a[3] == R) begin
        model_clear();
      end else begin
        m_fcnt++;
        if (m_fcnt == FHALF) begin
          m_fcnt = 0;
          m_off = !m_off;
        end
        for (int i = 0; i < 4; i++) m_sig[i] = m_off ? 3'b000 : R;
      end
    end else begin
      anyinv = 0; seq = 0; shrt = 0;
      for (int i = 0; i < 4; i++) begin
        v[i]  = (a[i] == R) || (a[i] == Y) || (a[i] == G);
        e[i]  = v[i] ? a[i] : m_prev[i];
        ac[i] = (e[i] != R);
        if (!v[i]) anyinv = 1;
        if (v[i] && !legal(m_prev[i], a[i])) seq = 1;
        if (v[i] && m_prev[i] == Y && a[i] == R && m_ycnt[i] < MIN_Y) shrt = 1;
      end
      conf = (ac[3] && (ac[0] || ac[1] || ac[2])) || (ac[2] && ac[1]);
      invf = anyinv && (m_inv + 1 >= GLITCH);
      code = conf ? 2 : invf ? 1 : seq ? 4 : shrt ? 3 : 0;
      if (code != 0) begin
        m_flt = 1; m_code = 3'(code); m_fcnt = 0; m_off = 0;
        for (int i = 0; i < 4; i++) m_sig[i] = R;
      end else begin
        for (int i = 0; i < 4; i++) begin
          m_sig[i] = e[i];
          m_prev[i] = e[i];
          if (v[i]) m_ycnt[i] = (a[i] == Y) ? ((m_ycnt[i] < MIN_Y) ? m_ycnt[i] + 1 : MIN_Y) : 0;
        end
        m_inv = anyinv ? m_inv + 1 : 0;
      end
    end
  endtask

  task automatic step(input string tag, input logic [2:0] m1, m2, mt, s,
                      input logic c, input logic r);
    exp_t e;
    @(negedge clk);
    l_m1 = m1; l_m2 = m2; l_mt = mt; l_s = s; clr = c; rst = r;
    model_step(m1, m2, mt, s, c, r);
    e.sig  = {m_sig[3], m_sig[2], m_sig[1], m_sig[0]};
    e.flt  = m_flt;
    e.code = m_code;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".sig"},   32'({sig_S, sig_MT, sig_M2, sig_M1}), 32'(e.sig));
    chk({tag, ".fault"}, 32'(fault), 32'(e.flt));
    chk({tag, ".code"},  32'(fault_code), 32'(e.code));
  endtask

  logic [2:0] cur[4];

  function automatic logic [2:0] next_legal(input logic [2:0] v);
    case (v)
      R:       return G;
      G:       return Y;
      Y:       return R;
      default: return R;
    endcase
  endfunction

  initial begin
    rst = 1'b1; clr = 1'b0; l_m1 = R; l_m2 = R; l_mt = R; l_s = R;
    model_clear();

    step("reset", R, R, R, R, 0, 1);
    step("reset", R, R, R, R, 0, 1);
    chk("reset_sigS", 32'(sig_S), 32'(R));
    chk("reset_fault", 32'(fault), 32'(0));

    // Normal cycle on M1/M2
    repeat (5) step("norm_g", G, G, R, R, 0, 0);
    chk("norm_sigM1", 32'(sig_M1), 32'(G));
    repeat (2) step("norm_y", Y, Y, R, R, 0, 0);
    step("norm_r", R, R, R, R, 0, 0);
    chk("norm_fault", 32'(fault), 32'(0));

    // Conflict, flash, rejected clear, accepted clear
    step("conf", G, R, R, G, 0, 0);
    chk("conf_code", 32'(fault_code), 32'(3'b010));
    step("flash0", G, R, R, G, 0, 0);
    chk("flash_off", 32'(sig_S), 32'(3'b000));
    step("flash1", G, R, R, G, 0, 0);
    step("clr_bad", G, R, R, R, 1, 0);
    chk("clr_bad_fault", 32'(fault), 32'(1));
    step("clr_ok", R, R, R, R, 1, 0);
    chk("clr_ok_fault", 32'(fault), 32'(0));

    // Short yellow then a properly timed yellow
    step("sy_g", R, G, R, R, 0, 0);
    step("sy_y", R, Y, R, R, 0, 0);
    step("sy_r", R, R, R, R, 0, 0);
    chk("short_code", 32'(fault_code), 32'(3'b011));
    step("sy_clr", R, R, R, R, 1, 0);
    step("ly_g", R, G, R, R, 0, 0);
    step("ly_y", R, Y, R, R, 0, 0);
    step("ly_y", R, Y, R, R, 0, 0);
    step("ly_r", R, R, R, R, 0, 0);
    chk("long_y_fault", 32'(fault), 32'(0));

    // Invalid encoding: one glitch absorbed, two make a fault
    step("inv1", R, R, R, BAD, 0, 0);
    chk("inv1_hold", 32'(sig_S), 32'(R));
    step("inv1_r", R, R, R, R, 0, 0);
    step("inv2a", R, R, R, BAD, 0, 0);
    step("inv2b", R, R, R, BAD, 0, 0);
    chk("inv_code", 32'(fault_code), 32'(3'b001));
    step("inv_clr", R, R, R, R, 1, 0);

    // Illegal sequence, then conflict outranking sequence
    step("seq_g", R, R, G, R, 0, 0);
    step("seq_r", R, R, R, R, 0, 0);
    chk("seq_code", 32'(fault_code), 32'(3'b100));
    step("seq_clr", R, R, R, R, 1, 0);
    step("pri_g", G, G, R, R, 0, 0);
    step("pri", R, G, R, G, 0, 0);
    chk("pri_code", 32'(fault_code), 32'(3'b010));

    // Reset mid-flash wins over a valid clear
    step("mid_flash", R, G, R, G, 0, 0);
    step("mid_rst", R, R, R, R, 1, 1);
    chk("mid_rst_fault", 32'(fault), 32'(0));
    step("post_rst", R, R, R, R, 0, 0);

    // Constrained random traffic against the model
    for (int i = 0; i < 4; i++) cur[i] = R;
    for (int n = 0; n < 600; n++) begin
      logic c, r;
      c = 0;
      r = ($urandom_range(0, 199) == 0);
      if (m_flt) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int i = 0; i < 4; i++) cur[i] = R;
          c = 1;
        end else begin
          c = 1'($urandom_range(0, 1));
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          int p;
          p = $urandom_range(0, 99);
          if (p < 8) cur[i] = next_legal(cur[i]);
          else if (p < 11) cur[i] = 3'($urandom_range(0, 7));
        end
      end
      step("rand", cur[0], cur[1], cur[2], cur[3], c, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
